// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, latencies and FSM state encodings.
package mdu_ctrl_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5,
        MDU_MFHI  = 3'd6,
        MDU_MFLO  = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } mdu_state_e;

    localparam int MUL_CYCLES = 5;
    localparam int DIV_CYCLES = 10;
    localparam int CNT_W      = 4;

    function automatic logic is_start_op(input mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit multiply/divide result from the operands latched by mdu_ctrl.
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  mdu_op_e     op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] divisor;
    logic               div_ovf;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;

    assign prod_s   = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
    assign prod_u   = {32'b0, rs} * {32'b0, rt};
    assign div_zero = (rt == 32'd0);
    // Substitute a harmless divisor so the dividers never see zero.
    assign divisor  = div_zero ? 32'd1 : rt;
    assign div_ovf  = (rs == 32'h8000_0000) && (rt == 32'hFFFF_FFFF);

    always_comb begin
        quot_s = $signed(rs) / $signed(divisor);
        rem_s  = $signed(rs) % $signed(divisor);
        if (div_ovf) begin
            quot_s = $signed(32'h8000_0000);
            rem_s  = '0;
        end
    end

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        case (op)
            MDU_MULT:  {res_hi, res_lo} = prod_s;
            MDU_MULTU: {res_hi, res_lo} = prod_u;
            MDU_DIV:   begin
                res_hi = rem_s;
                res_lo = quot_s;
            end
            MDU_DIVU:  begin
                res_hi = rs % divisor;
                res_lo = rs / divisor;
            end
            default:   ;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU sequencing: IDLE/MUL/DIV FSM, latency counter and architectural HI/LO registers.
// Optional macro MDU_FLUSH_EN lets flush suppress the same-cycle E-stage op; otherwise flush is ignored.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        E_mdu_valid,
    input  logic [2:0]  E_mdu_op,
    input  logic [31:0] E_rs,
    input  logic [31:0] E_rt,
    input  logic        flush,
    input  logic        D_HILO_operation,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] E_hilo_rd,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mdu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    mdu_op_e           op_q, op_d;
    logic [31:0]       rs_q, rs_d, rt_q, rt_d;
    logic [31:0]       hi_q, hi_d, lo_q, lo_d;
    logic [31:0]       res_hi, res_lo;
    logic              div_zero;
    logic              flush_eff;
    logic              op_accept;
    mdu_op_e           e_op;

`ifdef MDU_FLUSH_EN
    assign flush_eff = flush;
`else
    assign flush_eff = flush & 1'b0;
`endif

    assign e_op      = mdu_op_e'(E_mdu_op);
    assign op_accept = E_mdu_valid & ~flush_eff;

    mdu_arith u_arith (
        .op       (op_q),
        .rs       (rs_q),
        .rt       (rt_q),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .div_zero (div_zero)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (op_accept) begin
                    case (e_op)
                        MDU_MULT, MDU_MULTU: begin
                            state_d = ST_MUL;
                            cnt_d   = CNT_W'(MUL_CYCLES - 1);
                            op_d    = e_op;
                            rs_d    = E_rs;
                            rt_d    = E_rt;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            state_d = ST_DIV;
                            cnt_d   = CNT_W'(DIV_CYCLES - 1);
                            op_d    = e_op;
                            rs_d    = E_rs;
                            rt_d    = E_rt;
                        end
                        MDU_MTHI: hi_d = E_rs;
                        MDU_MTLO: lo_d = E_rs;
                        default:  ;
                    endcase
                end
            end
            // New E-stage ops are dropped while busy, including on the commit edge.
            ST_MUL, ST_DIV: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    if (!((state_q == ST_DIV) && div_zero)) begin
                        hi_d = res_hi;
                        lo_d = res_lo;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= MDU_MULT;
            rs_q    <= '0;
            rt_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign stall_req = ~reset & D_HILO_operation & (busy | (E_mdu_valid & is_start_op(e_op)));
    assign hi        = hi_q;
    assign lo        = lo_q;

    always_comb begin
        E_hilo_rd = '0;
        if (E_mdu_valid) begin
            if (e_op == MDU_MFHI)      E_hilo_rd = hi_q;
            else if (e_op == MDU_MFLO) E_hilo_rd = lo_q;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed corner cases plus random op streams against a cycle-count reference model.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        E_mdu_valid = 1'b0;
    logic [2:0]  E_mdu_op = 3'd0;
    logic [31:0] E_rs = '0;
    logic [31:0] E_rt = '0;
    logic        flush = 1'b0;
    logic        D_HILO_operation = 1'b0;
    logic        busy, stall_req;
    logic [31:0] E_hilo_rd, hi, lo;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: architectural HI/LO plus the number of busy cycles still owed.
    logic [31:0] m_hi, m_lo;
    int          m_left;
    logic [63:0] m_pend;
    bit          m_pend_ok;

    logic        last_stall;
    logic [31:0] last_hilo;

    always #5 clk = ~clk;

    mdu_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .E_mdu_valid      (E_mdu_valid),
        .E_mdu_op         (E_mdu_op),
        .E_rs             (E_rs),
        .E_rt             (E_rt),
        .flush            (flush),
        .D_HILO_operation (D_HILO_operation),
        .busy             (busy),
        .stall_req        (stall_req),
        .E_hilo_rd        (E_hilo_rd),
        .hi               (hi),
        .lo               (lo)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit flush_eff();
`ifdef MDU_FLUSH_EN
        return flush;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_edge();
        longint q, r;
        if (reset) begin
            m_hi = '0; m_lo = '0; m_left = 0; m_pend_ok = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_pend_ok) {m_hi, m_lo} = m_pend;
        end else if (E_mdu_valid && !flush_eff()) begin
            case (E_mdu_op)
                3'd0: begin
                    m_pend = longint'($signed(E_rs)) * longint'($signed(E_rt));
                    m_pend_ok = 1; m_left = 5;
                end
                3'd1: begin
                    m_pend = longint'({32'b0, E_rs}) * longint'({32'b0, E_rt});
                    m_pend_ok = 1; m_left = 5;
                end
                3'd2, 3'd3: begin
                    m_left = 10;
                    m_pend_ok = (E_rt != 0);
                    if (m_pend_ok) begin
                        if (E_mdu_op == 3'd2) begin
                            q = longint'($signed(E_rs)) / longint'($signed(E_rt));
                            r = longint'($signed(E_rs)) % longint'($signed(E_rt));
                        end else begin
                            q = longint'({32'b0, E_rs}) / longint'({32'b0, E_rt});
                            r = longint'({32'b0, E_rs}) % longint'({32'b0, E_rt});
                        end
                        m_pend = {r[31:0], q[31:0]};
                    end
                end
                3'd4: m_hi = E_rs;
                3'd5: m_lo = E_rs;
                default: ;
            endcase
        end
    endtask

    task automatic cyc(input bit r, input bit v, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b, input bit f, input bit d);
        logic exp_stall;
        logic [31:0] exp_rd;
        @(negedge clk);
        reset = r; E_mdu_valid = v; E_mdu_op = op; E_rs = a; E_rt = b;
        flush = f; D_HILO_operation = d;
        #1;
        exp_stall = !r && d && ((m_left > 0) || (v && op <= 3'd3));
        chk("stall_req", stall_req, exp_stall);
        last_stall = stall_req;
        last_hilo  = E_hilo_rd;
        if (v && (op == 3'd6 || op == 3'd7)) begin
            exp_rd = (op == 3'd6) ? m_hi : m_lo;
            chk("E_hilo_rd", E_hilo_rd, exp_rd);
        end
        @(posedge clk);
        model_edge();
        #1;
        chk("busy", busy, m_left > 0);
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
    endtask

    task automatic idle(input int n, output int busy_cnt, output int stall_cnt, input bit d);
        busy_cnt = 0; stall_cnt = 0;
        for (int i = 0; i < n; i++) begin
            cyc(0, 0, 3'd0, '0, '0, 0, d);
            if (last_stall) stall_cnt++;
            if (busy) busy_cnt++;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int bc, sc, nb;
        m_hi = '0; m_lo = '0; m_left = 0; m_pend_ok = 0; m_pend = '0;
        cyc(1, 1, 3'd4, 32'hDEAD, 0, 0, 1);
        cyc(1, 0, 3'd0, 0, 0, 0, 0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_hi", hi, 32'd0);

        cyc(0, 1, 3'd0, 32'hFFFF_FFFF, 32'd2, 0, 0);
        nb = busy;
        idle(6, bc, sc, 0);
        chk("mult_busy_cycles", nb + bc, 5);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFE);

        cyc(0, 1, 3'd1, 32'hFFFF_FFFF, 32'd2, 0, 0);
        idle(6, bc, sc, 0);
        chk("multu_hi", hi, 32'd1);
        chk("multu_lo", lo, 32'hFFFF_FFFE);

        cyc(0, 1, 3'd2, 32'hFFFF_FFF9, 32'd2, 0, 0);
        nb = busy;
        idle(11, bc, sc, 0);
        chk("div_busy_cycles", nb + bc, 10);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        cyc(0, 1, 3'd2, 32'd100, 32'd0, 0, 0);
        nb = busy;
        idle(11, bc, sc, 0);
        chk("div0_busy_cycles", nb + bc, 10);
        chk("div0_hi", hi, 32'hFFFF_FFFF);
        chk("div0_lo", lo, 32'hFFFF_FFFD);

        cyc(0, 1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        idle(11, bc, sc, 0);
        chk("divovf_lo", lo, 32'h8000_0000);
        chk("divovf_hi", hi, 32'd0);

        cyc(0, 1, 3'd0, 32'd3, 32'd5, 0, 1);
        sc = last_stall;
        idle(7, bc, nb, 1);
        chk("stall_cycles", sc + nb, 6);
        chk("stall_after", last_stall, 1'b0);
        cyc(0, 1, 3'd7, 0, 0, 0, 0);
        chk("mflo_product", last_hilo, 32'd15);

        cyc(0, 1, 3'd5, 32'h1234, 0, 1, 0);
`ifdef MDU_FLUSH_EN
        chk("mtlo_flush", lo, 32'd15);
`else
        chk("mtlo_flush", lo, 32'h1234);
`endif
        cyc(0, 1, 3'd0, 32'd2, 32'd2, 1, 0);
`ifdef MDU_FLUSH_EN
        chk("mult_flush_busy", busy, 1'b0);
`else
        chk("mult_flush_busy", busy, 1'b1);
`endif
        idle(6, bc, sc, 0);

        cyc(0, 1, 3'd4, 32'hABCD, 0, 0, 0);
        cyc(0, 1, 3'd2, 32'd50, 32'd7, 0, 0);
        cyc(0, 0, 3'd0, 0, 0, 0, 0);
        cyc(0, 0, 3'd0, 0, 0, 0, 0);
        cyc(1, 1, 3'd4, 32'h5555, 0, 0, 1);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);
        idle(12, bc, sc, 0);
        cyc(0, 1, 3'd6, 0, 0, 0, 0);
        chk("mfhi_after_rst", last_hilo, 32'd0);

        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7,
                3'($urandom_range(0, 7)), pick(), pick(),
                $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; clock and reset ports are named clk and reset.
REQ-002 SHALL provide these ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- E_mdu_valid  in  1  E-stage instruction is an MDU op
- E_mdu_op  in  3  op code from shared package
- E_rs  in  32  forwarded rs value
- E_rt  in  32  forwarded rt value
- flush  in  1  exception/interrupt taken this cycle; suppresses the E-stage op
- D_HILO_operation  in  1  D-stage instruction uses the MDU
- busy  out  1  multi-cycle operation in flight
- stall_req  out  1  stall request for D
- E_hilo_rd  out  32  HI or LO value for mfhi/mflo
- hi  out  32  architectural HI
- lo  out  32  architectural LO

Function
REQ-003 SHALL implement the FSM states IDLE, MUL and DIV; busy = (state != IDLE).
REQ-004 At an edge with E_mdu_valid=1, flush=0, state=IDLE and op in {mult, multu}: SHALL latch both operands, enter MUL and load cnt=4.
REQ-005 At an edge with the same conditions and op in {div, divu}: SHALL latch both operands, enter DIV and load cnt=9.
REQ-006 In MUL or DIV: cnt SHALL decrement each cycle; at the edge where cnt==0, the FSM SHALL commit HI/LO and return to IDLE.
REQ-007 busy SHALL be high for exactly 5 cycles (mult/multu) or 10 cycles (div/divu), starting the cycle after start.
REQ-008 mult: {HI,LO} = signed 64-bit product; multu: unsigned 64-bit product.
REQ-009 div: LO = quotient truncated toward zero, HI = remainder carrying the dividend's sign; divu: unsigned quotient/remainder.
REQ-010 Divide with rt==0 SHALL still hold busy for 10 cycles and SHALL leave HI/LO unchanged.
REQ-011 div 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-012 mthi/mtlo with E_mdu_valid=1 and flush=0 SHALL write E_rs into HI/LO at that edge, with no busy cycles.
REQ-013 E_hilo_rd SHALL be combinational: HI for mfhi, LO for mflo, 0 otherwise.
REQ-014 stall_req = D_HILO_operation & (busy | (E_mdu_valid & op is mult/multu/div/divu)).
REQ-015 flush SHALL suppress only the same-cycle E-stage op; an operation already in MUL or DIV SHALL run to completion and commit.
REQ-016 A start or mt op arriving while busy is illegal (prevented by REQ-014); if it occurs, it SHALL be ignored and the current operation SHALL be unaffected.
REQ-017 On the commit edge, a simultaneous mthi/mtlo is illegal and SHALL be ignored.

Reset
REQ-018 reset SHALL force state=IDLE, cnt=0, hi=lo=0, busy=0 and stall_req=0, including mid-operation; any in-flight result SHALL be discarded.
REQ-019 While reset is high, all inputs SHALL be ignored.

Configuration
REQ-020 With macro MDU_FLUSH_EN defined, flush SHALL behave as in REQ-004/005/012/015.
REQ-021 Without MDU_FLUSH_EN, flush SHALL be ignored and treated as constant 0; the port SHALL remain present.

Structure
REQ-022 A shared package SHALL hold the MDU_OP codes (MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO), MUL_CYCLES=5, DIV_CYCLES=10 and the state encodings.
REQ-023 The 64-bit result computation SHALL live in one sub-module, mdu_arith (combinational, from latched operands); the FSM, counter and HI/LO registers SHALL stay in mdu_ctrl.

Verification
REQ-024 mult with rs=0xFFFFFFFF, rt=2: busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu with the same operands: HI=1, LO=0xFFFFFFFE.
REQ-025 div with rs=-7, rt=2: busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; div with rt=0: busy 10 cycles, HI/LO unchanged.
REQ-026 Start mult, then hold D_HILO_operation=1: stall_req high in the start cycle and for 5 busy cycles, low afterwards; mflo then returns the product.
REQ-027 mtlo rs=0x1234 with flush=1: LO unchanged (MDU_FLUSH_EN defined) or LO=0x1234 (undefined); start mult with flush=1: busy stays 0.
REQ-028 reset asserted at busy cycle 3 of a div: next cycle busy=0 and hi=lo=0; later mfhi returns 0.
